// File: rtl/uart_pkg.sv
// Shared UART definitions: line FSM states and 8N1 frame constants.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int DATA_BITS  = 8;
    localparam int FRAME_BITS = 10;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_tx_if.sv
// Producer-side byte handshake plus serial line and status for uart_tx.
interface uart_tx_if #(
    parameter int FIFO_DEPTH = 16
);
    import uart_pkg::*;

    localparam int LEVEL_W = $clog2(FIFO_DEPTH + 1);

    logic                 in_valid;
    logic [DATA_BITS-1:0] in_data;
    logic                 in_ready;
    logic                 tx;
    logic                 busy;
    logic [LEVEL_W-1:0]   fifo_level;

    modport master (
        output in_valid, in_data,
        input  in_ready, tx, busy, fifo_level
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, tx, busy, fifo_level
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read data and an occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int LEVEL_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (level == LEVEL_W'(DEPTH));
    assign empty    = (level == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Storage: written only on an accepted push, so in-flight data never changes.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and level; a simultaneous push and pop leaves level unchanged.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LEVEL_W'(1);
                2'b01:   level <= level - LEVEL_W'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter fed from a byte FIFO.
//
//   state | meaning
//   IDLE  | line high, waiting for a queued byte
//   START | driving the start bit (0)
//   DATA  | shifting out 8 data bits, LSB first
//   STOP  | driving the stop bit (1); may chain straight into the next START
//
// The FIFO is popped only from IDLE or on the last stop-bit cycle, so a freshly
// pushed byte always shows in fifo_level for at least one cycle.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic      clock,
    input  logic      reset,
    uart_tx_if.slave  bus
);

    localparam int CNT_W   = $clog2(CLKS_PER_BIT);
    localparam int IDX_W   = $clog2(FRAME_BITS);
    localparam int LEVEL_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    uart_state_t          state;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 tx_q;
    logic                 bit_end;
    logic                 pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] fifo_data;
    logic [LEVEL_W-1:0]   level;

    assign bit_end = (cnt == CNT_LAST);
    assign pop     = !fifo_empty && ((state == IDLE) || ((state == STOP) && bit_end));

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (bus.in_valid),
        .push_data (bus.in_data),
        .pop       (pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (level)
    );

    assign bus.in_ready   = !fifo_full;
    assign bus.fifo_level = level;
    assign bus.busy       = (state != IDLE) || !fifo_empty;
    assign bus.tx         = tx_q;

    // Line sequencer: bit timing, shift register and registered tx.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            tx_q    <= STOP_BIT;
        end else begin
            case (state)
                IDLE: begin
                    tx_q    <= STOP_BIT;
                    cnt     <= '0;
                    bit_idx <= '0;
                    if (pop) begin
                        shreg <= fifo_data;
                        tx_q  <= START_BIT;
                        state <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        cnt     <= '0;
                        bit_idx <= IDX_W'(1);
                        tx_q    <= shreg[0];
                        shreg   <= shreg >> 1;
                        state   <= DATA;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cnt <= '0;
                        if (bit_idx == IDX_W'(DATA_BITS)) begin
                            tx_q  <= STOP_BIT;
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + IDX_W'(1);
                            tx_q    <= shreg[0];
                            shreg   <= shreg >> 1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        if (pop) begin
                            shreg <= fifo_data;
                            tx_q  <= START_BIT;
                            state <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    tx_q  <= STOP_BIT;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: a 4-clock-per-bit instance for protocol detail
// and a 434-clock-per-bit instance decoded by a baud-rate serial monitor.
`timescale 1ns/1ps
module tb_uart_tx;

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #10 clock = ~clock;

    uart_tx_if #(.FIFO_DEPTH(16)) bus ();
    uart_tx_if #(.FIFO_DEPTH(16)) slow_bus ();

    uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(16)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    uart_tx #(.CLKS_PER_BIT(434), .FIFO_DEPTH(16)) dut_slow (
        .clock (clock),
        .reset (reset),
        .bus   (slow_bus)
    );

    int   checks   = 0;
    int   failures = 0;
    int   n_edges  = 0;
    logic trace [0:1023];

    // trace[e] holds the fast tx line just after edge e of the current test
    task automatic step();
        @(posedge clock);
        #1;
        n_edges++;
        trace[n_edges] = bus.tx;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic frame_bit(logic [7:0] d, int b);
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return d[b-1];
    endfunction

    function automatic int frame_errs(int s, logic [7:0] d);
        int n = 0;
        for (int p = 0; p < 40; p++) begin
            if (trace[s+p] !== frame_bit(d, p / 4)) n++;
        end
        return n;
    endfunction

    function automatic logic [7:0] decode(int s);
        logic [7:0] v;
        for (int b = 0; b < 8; b++) v[b] = trace[s + 4*(b+1) + 2];
        return v;
    endfunction

    task automatic test_reset();
        bus.in_valid = 1'b0;
        bus.in_data = 8'h00;
        slow_bus.in_valid = 1'b0;
        slow_bus.in_data = 8'h00;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        checks++; if (bus.tx !== 1'b1) begin failures++; $display("FAIL reset_tx: got %b want 1", bus.tx); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        checks++; if (bus.fifo_level !== 5'd0) begin failures++; $display("FAIL reset_level: got %0d want 0", bus.fifo_level); end
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        reset = 1'b0;
    endtask

    task automatic test_single();
        n_edges = 0;
        bus.in_valid = 1'b1;
        bus.in_data = 8'h55;
        step();
        checks++; if (bus.fifo_level !== 5'd1) begin failures++; $display("FAIL single_queued_level: got %0d want 1", bus.fifo_level); end
        checks++; if (bus.tx !== 1'b1) begin failures++; $display("FAIL single_tx_before_start: got %b want 1", bus.tx); end
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL single_busy_queued: got %b want 1", bus.busy); end
        bus.in_valid = 1'b0;
        bus.in_data = 8'hFF;
        step();
        checks++; if (bus.tx !== 1'b0) begin failures++; $display("FAIL single_start_latency: got %b want 0", bus.tx); end
        checks++; if (bus.fifo_level !== 5'd0) begin failures++; $display("FAIL single_popped_level: got %0d want 0", bus.fifo_level); end
        while (n_edges < 41) step();
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL single_busy_last_stop: got %b want 1", bus.busy); end
        step();
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL single_busy_fall: got %b want 0", bus.busy); end
        checks++; if (bus.tx !== 1'b1) begin failures++; $display("FAIL single_idle_tx: got %b want 1", bus.tx); end
        checks++; if (frame_errs(2, 8'h55) !== 0) begin failures++; $display("FAIL single_pattern: got %0d bad cycles want 0", frame_errs(2, 8'h55)); end
        checks++; if (decode(2) !== 8'h55) begin failures++; $display("FAIL single_byte: got %h want 55", decode(2)); end
    endtask

    task automatic test_back_to_back();
        int errs;
        n_edges = 0;
        bus.in_valid = 1'b1;
        bus.in_data = 8'h41;
        step();
        bus.in_data = 8'h42;
        step();
        bus.in_data = 8'h43;
        step();
        bus.in_valid = 1'b0;
        while (n_edges < 121) step();
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL b2b_busy_last: got %b want 1", bus.busy); end
        step();
        checks++; if (bus.busy !== 1'b0 || bus.tx !== 1'b1) begin failures++; $display("FAIL b2b_idle: got busy=%b tx=%b want busy=0 tx=1", bus.busy, bus.tx); end
        errs = frame_errs(2, 8'h41) + frame_errs(42, 8'h42) + frame_errs(82, 8'h43);
        checks++; if (errs !== 0) begin failures++; $display("FAIL b2b_contiguous_pattern: got %0d bad cycles want 0", errs); end
        checks++; if (decode(2) !== 8'h41) begin failures++; $display("FAIL b2b_byte0: got %h want 41", decode(2)); end
        checks++; if (decode(42) !== 8'h42) begin failures++; $display("FAIL b2b_byte1: got %h want 42", decode(42)); end
        checks++; if (decode(82) !== 8'h43) begin failures++; $display("FAIL b2b_byte2: got %h want 43", decode(82)); end
    endtask

    task automatic test_fill();
        int accepted = 0;
        int errs = 0;
        n_edges = 0;
        for (int e = 1; e <= 682; e++) begin
            bus.in_valid = (e <= 20);
            bus.in_data = 8'(e - 1);
            if (bus.in_valid && bus.in_ready) accepted++;
            step();
            if (e == 20) begin
                checks++; if (bus.fifo_level !== 5'd16 || bus.in_ready !== 1'b0) begin failures++; $display("FAIL fill_full: got level=%0d ready=%b want level=16 ready=0", bus.fifo_level, bus.in_ready); end
            end
            if (e == 41) begin
                checks++; if (bus.fifo_level !== 5'd16 || bus.in_ready !== 1'b0) begin failures++; $display("FAIL fill_still_full: got level=%0d ready=%b want level=16 ready=0", bus.fifo_level, bus.in_ready); end
            end
            if (e == 42) begin
                checks++; if (bus.fifo_level !== 5'd15 || bus.in_ready !== 1'b1) begin failures++; $display("FAIL fill_ready_after_pop: got level=%0d ready=%b want level=15 ready=1", bus.fifo_level, bus.in_ready); end
            end
        end
        bus.in_valid = 1'b0;
        checks++; if (accepted !== 17) begin failures++; $display("FAIL fill_accepted: got %0d want 17", accepted); end
        checks++; if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.fifo_level !== 5'd0) begin failures++; $display("FAIL fill_drained: got tx=%b busy=%b level=%0d want 1 0 0", bus.tx, bus.busy, bus.fifo_level); end
        for (int f = 0; f < 17; f++) errs += frame_errs(2 + 40*f, 8'(f));
        checks++; if (errs !== 0) begin failures++; $display("FAIL fill_pattern: got %0d bad cycles want 0", errs); end
        for (int f = 0; f < 17; f++) begin
            checks++; if (decode(2 + 40*f) !== 8'(f)) begin failures++; $display("FAIL fill_order[%0d]: got %h want %h", f, decode(2 + 40*f), 8'(f)); end
        end
    endtask

    task automatic test_simultaneous();
        int errs;
        n_edges = 0;
        for (int e = 1; e <= 122; e++) begin
            bus.in_valid = (e == 1) || (e == 3) || (e == 42);
            bus.in_data = (e == 1) ? 8'hA5 : (e == 3) ? 8'h3C : 8'hC3;
            step();
            if (e == 41) begin
                checks++; if (bus.fifo_level !== 5'd1) begin failures++; $display("FAIL simul_level_before: got %0d want 1", bus.fifo_level); end
            end
            if (e == 42) begin
                checks++; if (bus.fifo_level !== 5'd1) begin failures++; $display("FAIL simul_level_push_pop: got %0d want 1", bus.fifo_level); end
                checks++; if (bus.tx !== 1'b0) begin failures++; $display("FAIL simul_no_gap: got %b want 0", bus.tx); end
            end
            if (e == 82) begin
                checks++; if (bus.fifo_level !== 5'd0) begin failures++; $display("FAIL simul_level_last_pop: got %0d want 0", bus.fifo_level); end
            end
        end
        bus.in_valid = 1'b0;
        errs = frame_errs(2, 8'hA5) + frame_errs(42, 8'h3C) + frame_errs(82, 8'hC3);
        checks++; if (errs !== 0) begin failures++; $display("FAIL simul_pattern: got %0d bad cycles want 0", errs); end
        checks++; if (decode(42) !== 8'h3C) begin failures++; $display("FAIL simul_order_b: got %h want 3c", decode(42)); end
        checks++; if (decode(82) !== 8'hC3) begin failures++; $display("FAIL simul_order_c: got %h want c3", decode(82)); end
        checks++; if (bus.tx !== 1'b1 || bus.busy !== 1'b0) begin failures++; $display("FAIL simul_idle: got tx=%b busy=%b want 1 0", bus.tx, bus.busy); end
    endtask

    task automatic test_reset_mid();
        int errs = 0;
        n_edges = 0;
        for (int e = 1; e <= 12; e++) begin
            bus.in_valid = (e <= 6);
            bus.in_data = (e == 1) ? 8'h00 : 8'(8'h10 + e);
            step();
        end
        bus.in_valid = 1'b0;
        checks++; if (bus.fifo_level !== 5'd5) begin failures++; $display("FAIL rstmid_queued: got %0d want 5", bus.fifo_level); end
        checks++; if (bus.tx !== 1'b0) begin failures++; $display("FAIL rstmid_tx_low_before: got %b want 0", bus.tx); end
        #2 reset = 1'b1;
        #1;
        checks++; if (bus.tx !== 1'b1) begin failures++; $display("FAIL rstmid_tx_async: got %b want 1", bus.tx); end
        checks++; if (bus.fifo_level !== 5'd0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin failures++; $display("FAIL rstmid_flush: got level=%0d busy=%b ready=%b want 0 0 1", bus.fifo_level, bus.busy, bus.in_ready); end
        @(posedge clock);
        #1 reset = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (bus.tx !== 1'b1 || bus.busy !== 1'b0) errs++;
        end
        checks++; if (errs !== 0) begin failures++; $display("FAIL rstmid_no_frames: got %0d active cycles want 0", errs); end
    endtask

    task automatic test_baud();
        logic [7:0] want [3];
        logic [7:0] ch;
        logic       start_b;
        logic       stop_b;
        int         t;
        want[0] = 8'h4F;
        want[1] = 8'h4B;
        want[2] = 8'h0A;
        ch = 8'h00;
        slow_bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            slow_bus.in_data = want[i];
            tick();
        end
        slow_bus.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            t = 0;
            while (slow_bus.tx !== 1'b0 && t < 10000) begin
                tick();
                t++;
            end
            checks++;
            if (t >= 10000) begin
                failures++;
                $display("FAIL baud_start_timeout[%0d]: got no start bit want start within 10000 cycles", i);
            end else begin
                repeat (217) tick();
                start_b = slow_bus.tx;
                for (int b = 0; b < 8; b++) begin
                    repeat (434) tick();
                    ch[b] = slow_bus.tx;
                end
                repeat (434) tick();
                stop_b = slow_bus.tx;
                if ({stop_b, ch, start_b} !== {1'b1, want[i], 1'b0}) begin
                    failures++;
                    $display("FAIL baud_char[%0d]: got %h start=%b stop=%b want %h start=0 stop=1", i, ch, start_b, stop_b, want[i]);
                end
                $write("%c", ch);
            end
        end
        if (ch !== 8'h0A) $display("");
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_fill();
        test_simultaneous();
        test_reset_mid();
        test_baud();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
